// File: rtl/chiplet_endnode.sv
// Link-layer endpoint: frames and 4B5B-encodes 40-bit flits toward a 5-bit UART PHY, decodes received words.
// Optional build macro ENDNODE_ERR_CNT_EN adds a saturating err_cnt[7:0] output.
module chiplet_endnode #(
    parameter logic [3:0] FMT_KOMMA = 4'hF,
    parameter int         CRED_W    = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_tx,
    input  logic [39:0]       flit_tx,
    input  logic              send_next_flit_tx,
    input  logic              packet_done_tx,
    input  logic [CRED_W-1:0] grtcred_tx,
    output logic              get_data,
    output logic [49:0]       data_out_tx,
    output logic [3:0]        comma_sel_tx_out,
    output logic              start_out_tx,
    input  logic              done_tx,
    input  logic [49:0]       enc_flit_rx,
    input  logic [3:0]        comma_length_sel_in_rx,
    input  logic              done_in_rx,
    input  logic              err_in_rx,
    output logic [39:0]       flit_rx,
    output logic              done_rx,
    output logic [CRED_W-1:0] grtcred_rx,
    output logic              err_rx
`ifdef ENDNODE_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [3:0] CS_DATA  = 4'd0;
    localparam logic [3:0] CS_START = 4'd1;
    localparam logic [3:0] CS_END   = 4'd2;
    localparam logic [3:0] CS_GRT0  = 4'd5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2,
        READY     = 2'd3
    } tx_state_e;

    function automatic logic [4:0] enc_sym(input logic [3:0] nib);
        logic [4:0] sym;
        case (nib)
            4'h0:    sym = 5'b11110;
            4'h1:    sym = 5'b01001;
            4'h2:    sym = 5'b10100;
            4'h3:    sym = 5'b10101;
            4'h4:    sym = 5'b01010;
            4'h5:    sym = 5'b01011;
            4'h6:    sym = 5'b01110;
            4'h7:    sym = 5'b01111;
            4'h8:    sym = 5'b10010;
            4'h9:    sym = 5'b10011;
            4'hA:    sym = 5'b10110;
            4'hB:    sym = 5'b10111;
            4'hC:    sym = 5'b11010;
            4'hD:    sym = 5'b11011;
            4'hE:    sym = 5'b11100;
            4'hF:    sym = 5'b11101;
            default: sym = 5'b11110;
        endcase
        return sym;
    endfunction

    // Result is {illegal, nibble}; illegal symbols decode to nibble 0.
    function automatic logic [4:0] dec_sym(input logic [4:0] sym);
        logic [4:0] res;
        case (sym)
            5'b11110: res = 5'h00;
            5'b01001: res = 5'h01;
            5'b10100: res = 5'h02;
            5'b10101: res = 5'h03;
            5'b01010: res = 5'h04;
            5'b01011: res = 5'h05;
            5'b01110: res = 5'h06;
            5'b01111: res = 5'h07;
            5'b10010: res = 5'h08;
            5'b10011: res = 5'h09;
            5'b10110: res = 5'h0A;
            5'b10111: res = 5'h0B;
            5'b11010: res = 5'h0C;
            5'b11011: res = 5'h0D;
            5'b11100: res = 5'h0E;
            5'b11101: res = 5'h0F;
            default:  res = 5'h10;
        endcase
        return res;
    endfunction

    function automatic logic [49:0] enc_flit(input logic [39:0] flit);
        logic [49:0] word;
        word = 50'd0;
        for (int i = 0; i < 10; i++) begin
            word[5*i +: 5] = enc_sym(flit[4*i +: 4]);
        end
        return word;
    endfunction

    function automatic logic [40:0] dec_flit(input logic [49:0] word);
        logic [39:0] flit;
        logic        bad;
        logic [4:0]  d;
        flit = 40'd0;
        bad  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            d              = dec_sym(word[5*i +: 5]);
            flit[4*i +: 4] = d[3:0];
            bad            = bad | d[4];
        end
        return {bad, flit};
    endfunction

    tx_state_e         state_q;
    tx_state_e         ret_q;
    logic              start_out_q;
    logic              get_data_q;
    logic [49:0]       data_out_q;
    logic [3:0]        comma_sel_q;
    logic [CRED_W-1:0] pending_q;
    logic [CRED_W-1:0] pending_d;
    logic [CRED_W-1:0] cred_clr_s;
    logic [3:0]        cred_code_s;
    logic              cred_go_s;
    logic              cred_take_s;

    // Lowest pending credit channel wins; it is cleared when its transfer is accepted.
    always_comb begin
        cred_clr_s  = pending_q & (~pending_q + CRED_W'(1));
        cred_code_s = 4'd0;
        for (int i = 0; i < CRED_W; i++) begin
            cred_code_s = cred_code_s | (cred_clr_s[i] ? (CS_GRT0 + 4'(i)) : 4'd0);
        end
        cred_go_s   = |pending_q;
        cred_take_s = cred_go_s && ((state_q == IDLE) || (state_q == READY));
        pending_d   = (pending_q & ~(cred_take_s ? cred_clr_s : '0)) | grtcred_tx;
    end

    // Pending credit-grant register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // TX sequencer: one PHY transfer at a time, credits ahead of packet traffic.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            start_out_q <= 1'b0;
            get_data_q  <= 1'b0;
            data_out_q  <= 50'd0;
            comma_sel_q <= 4'd0;
        end else begin
            start_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    get_data_q <= 1'b0;
                    if (cred_go_s) begin
                        comma_sel_q <= cred_code_s;
                        data_out_q  <= 50'd0;
                        start_out_q <= 1'b1;
                        ret_q       <= IDLE;
                        state_q     <= SEND;
                    end else if (start_tx) begin
                        if (flit_tx[31:28] == FMT_KOMMA) begin
                            comma_sel_q <= CS_DATA;
                            data_out_q  <= enc_flit(flit_tx);
                            ret_q       <= IDLE;
                        end else begin
                            comma_sel_q <= CS_START;
                            data_out_q  <= 50'd0;
                            ret_q       <= READY;
                        end
                        start_out_q <= 1'b1;
                        state_q     <= SEND;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SEND, WAIT_DONE: begin
                    if (done_tx) begin
                        state_q    <= ret_q;
                        get_data_q <= (ret_q == READY) && (pending_d == '0);
                    end else begin
                        state_q    <= WAIT_DONE;
                        get_data_q <= 1'b0;
                    end
                end
                READY: begin
                    if (cred_go_s) begin
                        get_data_q  <= 1'b0;
                        comma_sel_q <= cred_code_s;
                        data_out_q  <= 50'd0;
                        start_out_q <= 1'b1;
                        ret_q       <= READY;
                        state_q     <= SEND;
                    end else if (send_next_flit_tx) begin
                        get_data_q  <= 1'b0;
                        comma_sel_q <= CS_DATA;
                        data_out_q  <= enc_flit(flit_tx);
                        start_out_q <= 1'b1;
                        ret_q       <= READY;
                        state_q     <= SEND;
                    end else if (packet_done_tx) begin
                        get_data_q  <= 1'b0;
                        comma_sel_q <= CS_END;
                        data_out_q  <= 50'd0;
                        start_out_q <= 1'b1;
                        ret_q       <= IDLE;
                        state_q     <= SEND;
                    end else begin
                        get_data_q <= (pending_d == '0);
                        state_q    <= READY;
                    end
                end
                default: begin
                    get_data_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign get_data         = get_data_q;
    assign data_out_tx      = data_out_q;
    assign comma_sel_tx_out = comma_sel_q;
    assign start_out_tx     = start_out_q;

    logic [40:0]       rx_dec_s;
    logic [CRED_W-1:0] rx_grt_s;
    logic [39:0]       flit_rx_q;
    logic              done_rx_q;
    logic [CRED_W-1:0] grt_rx_q;
    logic              err_rx_q;

    // Decode the received word and classify credit commas.
    always_comb begin
        rx_dec_s = dec_flit(enc_flit_rx);
        rx_grt_s = '0;
        for (int i = 0; i < CRED_W; i++) begin
            rx_grt_s[i] = (comma_length_sel_in_rx == (CS_GRT0 + 4'(i)));
        end
    end

    // RX word handling; a PHY error or an illegal symbol leaves flit_rx untouched.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flit_rx_q <= 40'd0;
            done_rx_q <= 1'b0;
            grt_rx_q  <= '0;
            err_rx_q  <= 1'b0;
        end else begin
            done_rx_q <= 1'b0;
            grt_rx_q  <= '0;
            err_rx_q  <= 1'b0;
            if (done_in_rx) begin
                if (err_in_rx) begin
                    err_rx_q <= 1'b1;
                end else if (comma_length_sel_in_rx == CS_DATA) begin
                    if (rx_dec_s[40]) begin
                        err_rx_q <= 1'b1;
                    end else begin
                        flit_rx_q <= rx_dec_s[39:0];
                        done_rx_q <= 1'b1;
                    end
                end else begin
                    grt_rx_q <= rx_grt_s;
                end
            end
        end
    end

    assign flit_rx    = flit_rx_q;
    assign done_rx    = done_rx_q;
    assign grtcred_rx = grt_rx_q;
    assign err_rx     = err_rx_q;

`ifdef ENDNODE_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of err_rx pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_cnt_q <= 8'd0;
        end else if (err_rx_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end else begin
            err_cnt_q <= err_cnt_q;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_chiplet_endnode.sv
// Scoreboard bench for chiplet_endnode: a PHY model checks each TX word, completes it and loops it back into RX.
module tb_chiplet_endnode;

    localparam int         CRED_W   = 2;
    localparam logic [3:0] CS_DATA  = 4'd0;
    localparam logic [3:0] CS_START = 4'd1;
    localparam logic [3:0] CS_END   = 4'd2;
    localparam logic [3:0] CS_ACK   = 4'd3;
    localparam logic [3:0] CS_GRT0  = 4'd5;
    localparam logic [3:0] CS_GRT1  = 4'd6;
    localparam logic [4:0] SYM [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                                        5'b01010, 5'b01011, 5'b01110, 5'b01111,
                                        5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                        5'b11010, 5'b11011, 5'b11100, 5'b11101};

    logic              CLK;
    logic              RST;
    logic              start_tx;
    logic [39:0]       flit_tx;
    logic              send_next_flit_tx;
    logic              packet_done_tx;
    logic [CRED_W-1:0] grtcred_tx;
    logic              get_data;
    logic [49:0]       data_out_tx;
    logic [3:0]        comma_sel_tx_out;
    logic              start_out_tx;
    logic              done_tx;
    logic [49:0]       enc_flit_rx;
    logic [3:0]        comma_length_sel_in_rx;
    logic              done_in_rx;
    logic              err_in_rx;
    logic [39:0]       flit_rx;
    logic              done_rx;
    logic [CRED_W-1:0] grtcred_rx;
    logic              err_rx;
`ifdef ENDNODE_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif

    logic        phy_drx, inj_drx, inj_err, phy_busy;
    logic [49:0] phy_enc, inj_enc;
    logic [3:0]  phy_csel, inj_csel;
    logic [53:0] txq [$];
    logic [41:0] rxq [$];
    int          n_checks = 0;
    int          n_errs = 0;
    int          cyc = 0;
    int          last_done_cyc = 0;

    assign done_in_rx             = phy_drx | inj_drx;
    assign enc_flit_rx            = inj_drx ? inj_enc : phy_enc;
    assign comma_length_sel_in_rx = inj_drx ? inj_csel : phy_csel;
    assign err_in_rx              = inj_err;

    chiplet_endnode #(.FMT_KOMMA(4'hF), .CRED_W(CRED_W)) dut (
        .CLK(CLK), .RST(RST), .start_tx(start_tx), .flit_tx(flit_tx),
        .send_next_flit_tx(send_next_flit_tx), .packet_done_tx(packet_done_tx),
        .grtcred_tx(grtcred_tx), .get_data(get_data), .data_out_tx(data_out_tx),
        .comma_sel_tx_out(comma_sel_tx_out), .start_out_tx(start_out_tx), .done_tx(done_tx),
        .enc_flit_rx(enc_flit_rx), .comma_length_sel_in_rx(comma_length_sel_in_rx),
        .done_in_rx(done_in_rx), .err_in_rx(err_in_rx), .flit_rx(flit_rx), .done_rx(done_rx),
        .grtcred_rx(grtcred_rx), .err_rx(err_rx)
`ifdef ENDNODE_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [49:0] tb_enc(input logic [39:0] f);
        logic [49:0] e;
        e = 50'd0;
        for (int i = 0; i < 10; i++) e[5*i +: 5] = SYM[f[4*i +: 4]];
        return e;
    endfunction

    task automatic tx_pop(input logic [3:0] csel, input logic [49:0] data);
        logic [53:0] exp;
        if (txq.size() == 0) begin
            chk_eq("tx_unexpected", 64'(txq.size()), 64'd1);
        end else begin
            exp = txq.pop_front();
            chk_eq("tx_word", {csel, data}, exp);
        end
    endtask

    task automatic rx_pop(input logic [1:0] kind, input logic [39:0] f);
        logic [41:0] exp;
        if (rxq.size() == 0) begin
            chk_eq("rx_unexpected", 64'(rxq.size()), 64'd1);
        end else begin
            exp = rxq.pop_front();
            chk_eq("rx_event", {kind, f}, exp);
        end
    endtask

    // PHY model: checks each started word, completes it after a few cycles and loops it back.
    initial begin
        logic [49:0] w_data;
        logic [3:0]  w_csel;
        done_tx = 1'b0; phy_drx = 1'b0; phy_enc = 50'd0; phy_csel = 4'd0; phy_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (start_out_tx && !RST) begin
                phy_busy = 1'b1;
                w_data = data_out_tx;
                w_csel = comma_sel_tx_out;
                tx_pop(w_csel, w_data);
                repeat (3) @(posedge CLK);
                #1 done_tx = 1'b1; phy_drx = 1'b1; phy_enc = w_data; phy_csel = w_csel;
                @(posedge CLK);
                #1 done_tx = 1'b0; phy_drx = 1'b0; last_done_cyc = cyc;
                phy_busy = 1'b0;
            end
        end
    end

    // RX monitor: every output pulse must match the head of the RX scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            if (done_rx) rx_pop(2'd0, flit_rx);
            if (grtcred_rx[0]) rx_pop(2'd1, 40'd0);
            if (grtcred_rx[1]) rx_pop(2'd2, 40'd0);
            if (err_rx) rx_pop(2'd3, 40'd0);
        end
    end

    task automatic drive_start(input logic [39:0] f);
        @(posedge CLK); #1 flit_tx = f; start_tx = 1'b1;
        @(posedge CLK); #1 start_tx = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge CLK); #1 packet_done_tx = 1'b1;
        @(posedge CLK); #1 packet_done_tx = 1'b0;
    endtask

    task automatic pulse_cred(input logic [CRED_W-1:0] v);
        @(posedge CLK); #1 grtcred_tx = v;
        @(posedge CLK); #1 grtcred_tx = '0;
    endtask

    task automatic send_flit(input logic [39:0] f, input logic [49:0] exp_enc);
        txq.push_back({CS_DATA, exp_enc});
        rxq.push_back({2'd0, f});
        @(posedge CLK); #1 flit_tx = f; send_next_flit_tx = 1'b1;
        @(posedge CLK); #1 send_next_flit_tx = 1'b0;
        @(negedge CLK);
        chk_eq("gd_drop", 64'(get_data), 64'd0);
    endtask

    task automatic inject(input logic [3:0] csel, input logic [49:0] enc, input logic err);
        @(posedge CLK); #1 inj_drx = 1'b1; inj_csel = csel; inj_enc = enc; inj_err = err;
        @(posedge CLK); #1 inj_drx = 1'b0; inj_err = 1'b0;
    endtask

    task automatic wait_gd(output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (get_data) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk_eq("gd_timeout", 64'(get_data), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((txq.size() != 0 || rxq.size() != 0 || phy_busy) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 400) chk_eq("idle_timeout", 64'(txq.size() + rxq.size()), 64'd0);
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        logic [39:0] kflit;
        logic [49:0] w;
        int          at;
        RST = 1'b1; start_tx = 1'b0; flit_tx = 40'd0; send_next_flit_tx = 1'b0;
        packet_done_tx = 1'b0; grtcred_tx = '0;
        inj_drx = 1'b0; inj_err = 1'b0; inj_enc = 50'd0; inj_csel = 4'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_eq("rst_tx_ctl", {get_data, start_out_tx, comma_sel_tx_out}, 64'd0);
        chk_eq("rst_data_out", data_out_tx, 64'd0);
        chk_eq("rst_rx", {flit_rx, done_rx, grtcred_rx, err_rx}, 64'd0);
        @(posedge CLK); #1 RST = 1'b0;

        // Long write: START, header, two data words (all-zero / all-one encodings), END.
        txq.push_back({CS_START, 50'd0});
        drive_start(40'hA508675309);
        wait_gd(at);
        chk_eq("gd_latency", 64'(at), 64'(last_done_cyc));
        send_flit(40'hA508675309, tb_enc(40'hA508675309));
        wait_gd(at);
        send_flit(40'h0000000000, {10{5'b11110}});
        wait_gd(at);
        send_flit(40'hFFFFFFFFFF, {10{5'b11101}});
        wait_gd(at);
        txq.push_back({CS_END, 50'd0});
        pulse_done();
        wait_idle();

        // Credit grants while idle, one channel at a time.
        for (int ch = 0; ch < CRED_W; ch++) begin
            txq.push_back({CS_GRT0 + 4'(ch), 50'd0});
            rxq.push_back({2'(ch + 1), 40'd0});
            pulse_cred(CRED_W'(1) << ch);
            wait_idle();
        end

        // Packet-level pulses outside a packet are ignored.
        @(posedge CLK); #1 send_next_flit_tx = 1'b1; packet_done_tx = 1'b1;
        @(posedge CLK); #1 send_next_flit_tx = 1'b0; packet_done_tx = 1'b0;
        repeat (20) @(negedge CLK);
        chk_eq("idle_ignore_gd", 64'(get_data), 64'd0);

        // Both credits raised mid-word: data finishes, then GRTCRED0, GRTCRED1, then get_data.
        txq.push_back({CS_START, 50'd0});
        drive_start(40'h0112345678);
        wait_gd(at);
        send_flit(40'h3CDEADBEEF, tb_enc(40'h3CDEADBEEF));
        txq.push_back({CS_GRT0, 50'd0});
        txq.push_back({CS_GRT1, 50'd0});
        rxq.push_back({2'd1, 40'd0});
        rxq.push_back({2'd2, 40'd0});
        pulse_cred(2'b11);
        wait_gd(at);
        chk_eq("gd_after_creds", 64'(txq.size()), 64'd0);
        txq.push_back({CS_END, 50'd0});
        pulse_done();
        wait_idle();

        // Single control flit: one DATA word, no framing.
        kflit = {8'hA5, 4'hF, 5'h05, 19'h0, 4'h3};
        txq.push_back({CS_DATA, tb_enc(kflit)});
        rxq.push_back({2'd0, kflit});
        drive_start(kflit);
        @(negedge CLK);
        chk_eq("komma_start_lat", 64'(start_out_tx), 64'd1);
        wait_idle();
        chk_eq("komma_flit_rx", flit_rx, kflit);
        chk_eq("komma_no_gd", 64'(get_data), 64'd0);

        // RX errors leave flit_rx alone; unrelated commas produce nothing.
        rxq.push_back({2'd3, 40'd0});
        inject(CS_DATA, tb_enc(40'h1122334455), 1'b1);
        wait_idle();
        chk_eq("err_phy_hold", flit_rx, kflit);
        w = tb_enc(40'h1234567890);
        w[49:45] = 5'b00000;
        rxq.push_back({2'd3, 40'd0});
        inject(CS_DATA, w, 1'b0);
        wait_idle();
        chk_eq("err_sym_hold", flit_rx, kflit);
        inject(CS_ACK, 50'd0, 1'b0);
        inject(CS_START, 50'd0, 1'b0);
        rxq.push_back({2'd0, 40'h0F1E2D3C4B});
        inject(CS_DATA, tb_enc(40'h0F1E2D3C4B), 1'b0);
        wait_idle();
        chk_eq("rx_direct", flit_rx, 40'h0F1E2D3C4B);

        // Reset during a START transfer: the late PHY completion is ignored.
        txq.push_back({CS_START, 50'd0});
        drive_start(40'h0000000001);
        repeat (2) @(negedge CLK);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk_eq("rst_mid_start", 64'(start_out_tx), 64'd0);
        wait_idle();
        repeat (5) @(negedge CLK);
        chk_eq("rst_mid_gd", 64'(get_data), 64'd0);
        chk_eq("rst_mid_flit_rx", flit_rx, 40'd0);
        txq.push_back({CS_GRT1, 50'd0});
        rxq.push_back({2'd2, 40'd0});
        pulse_cred(2'b10);
        wait_idle();

`ifdef ENDNODE_ERR_CNT_EN
        chk_eq("err_cnt", 64'(err_cnt), 64'd2);
`endif
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
